cache_fill_ctrl: RTL and testbench

Cache miss fill controller for the data cache. On a miss it issues eight sequential word reads to the pipelined main memory and steers each returning word into the selected block of the 128-block data array. It drives the array's shared write strobe and one-hot word enable, then pulses the tag-array write once the last word lands. It sits between the miss-detect/tag-compare logic and main memory, directly upstream of the data array.

---
 rtl/cache_fill_ctrl.sv | 136 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill controller: issues eight word reads per miss and steers returns into the data array.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (fill starts at the missing word and wraps).
module cache_fill_ctrl #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [7:0]        word_enable,
  output logic [15:0]       fill_data,
  output logic              write_tag_array
);

  localparam int unsigned OFS_W  = 3;
  localparam int unsigned BASE_W = ADDR_W - 4;
  localparam logic [OFS_W-1:0] LAST_WORD = OFS_W'(7);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e            state_q;
  logic [OFS_W-1:0]  ic_q;
  logic [OFS_W-1:0]  rc_q;
  logic              done_q;
  logic              busy_q;
  logic              read_q;
  logic [BASE_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;

  logic [OFS_W-1:0]  first_c;
  logic [OFS_W-1:0]  miss_first_c;
  logic [OFS_W-1:0]  issue_ofs_d;
  logic [OFS_W-1:0]  rx_ofs_c;
  logic              rx_fire_c;
  logic              unused_miss_lsb;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFS_W-1:0]  first_q;
  assign first_c      = first_q;
  assign miss_first_c = miss_address[3:1];
`else
  assign first_c      = '0;
  assign miss_first_c = '0;
`endif

  // Byte offset within a word never matters; word offset matters only for critical-word-first.
  assign unused_miss_lsb = ^miss_address[3:0];

  always_comb begin
    issue_ofs_d = ic_q + OFS_W'(1) + first_c;
    rx_ofs_c    = rc_q + first_c;
    rx_fire_c   = (state_q == S_FILL) && memory_data_valid;
  end

  // Receive side is combinational so a returning word lands in the array the cycle it arrives.
  always_comb begin
    write_data_array = rx_fire_c;
    word_enable      = rx_fire_c ? (8'b1 << rx_ofs_c) : 8'b0;
    fill_data        = memory_data;
    write_tag_array  = rx_fire_c && (rc_q == LAST_WORD);
  end

  assign fsm_busy       = busy_q;
  assign memory_read    = read_q;
  assign memory_address = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ic_q    <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      read_q  <= 1'b0;
      base_q  <= '0;
      addr_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      first_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_detected) begin
            state_q <= S_FILL;
            busy_q  <= 1'b1;
            ic_q    <= '0;
            rc_q    <= '0;
            done_q  <= 1'b0;
            read_q  <= 1'b1;
            base_q  <= miss_address[ADDR_W-1:4];
            addr_q  <= {miss_address[ADDR_W-1:4], miss_first_c, 1'b0};
`ifdef CRITICAL_WORD_FIRST_EN
            first_q <= miss_address[3:1];
`endif
          end
        end
        S_FILL: begin
          // Issue side: ic_q is the index of the request currently on the bus.
          if (!done_q) begin
            if (ic_q == LAST_WORD) begin
              done_q <= 1'b1;
              read_q <= 1'b0;
            end else begin
              ic_q   <= ic_q + OFS_W'(1);
              addr_q <= {base_q, issue_ofs_d, 1'b0};
            end
          end
          // Receive side: the eighth accepted word ends the fill.
          if (memory_data_valid) begin
            rc_q <= rc_q + OFS_W'(1);
            if (rc_q == LAST_WORD) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              ic_q    <= '0;
              rc_q    <= '0;
              done_q  <= 1'b0;
              read_q  <= 1'b0;
              addr_q  <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a latency/gap-configurable pipelined memory model.
// Honors CRITICAL_WORD_FIRST_EN to select the expected word order.
module tb_cache_fill_ctrl;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [7:0]  word_enable;
  logic [15:0] fill_data;
  logic        write_tag_array;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  cache_fill_ctrl #(.ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_enable       (word_enable),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errors;
  int cyc;
  int mem_lat;
  int mem_gap;
  bit inj_valid;
  int due_q[$];
  logic [15:0] ret_q[$];
  int next_ok;

  int req_cnt, wr_cnt, tag_cnt, tag_wr, tag_cyc, busy_cnt, stray_en;
  bit last_busy;
  logic [15:0] req_addr [64];
  int          req_cyc  [64];
  logic [7:0]  wr_en    [64];
  logic [15:0] wr_dat   [64];
  logic [7:0]  tag_en;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  function automatic logic [2:0] tb_off(input int n, input logic [2:0] first);
    return 3'(n) + (CWF ? first : 3'd0);
  endfunction

  function automatic logic [15:0] exp_addr(input logic [11:0] hi, input int n, input logic [2:0] first);
    return {hi, tb_off(n, first), 1'b0};
  endfunction

  task automatic clear_log();
    req_cnt = 0; wr_cnt = 0; tag_cnt = 0; tag_wr = -1; tag_cyc = -1;
    busy_cnt = 0; stray_en = 0; tag_en = 8'h00;
    due_q.delete(); ret_q.delete(); next_ok = 0;
  endtask

  // One clock: sample outputs at negedge, then drive memory returns just after posedge.
  task automatic tick();
    @(negedge clk);
    last_busy = fsm_busy;
    if (fsm_busy) busy_cnt++;
    if (memory_read) begin
      req_addr[req_cnt % 64] = memory_address;
      req_cyc[req_cnt % 64]  = cyc;
      req_cnt++;
      due_q.push_back(cyc + mem_lat);
      ret_q.push_back(memory_address);
    end
    if (write_data_array) begin
      wr_en[wr_cnt % 64]  = word_enable;
      wr_dat[wr_cnt % 64] = fill_data;
      wr_cnt++;
    end else if (word_enable != 8'h00) begin
      stray_en++;
    end
    if (write_tag_array) begin
      tag_cnt++; tag_en = word_enable; tag_wr = wr_cnt; tag_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    if (inj_valid) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hDEAD;
    end else if (due_q.size() != 0 && due_q[0] <= cyc && cyc >= next_ok) begin
      void'(due_q.pop_front());
      memory_data       = data_of(ret_q.pop_front());
      memory_data_valid = 1'b1;
      next_ok           = cyc + 1 + mem_gap;
    end
  endtask

  task automatic run_fill(input logic [15:0] addr, input int toggle_n, output bit timed_out);
    miss_address  = addr;
    miss_detected = 1'b1;
    tick();
    miss_detected = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      miss_detected = (i < toggle_n) && (i % 2 == 0);
      miss_address  = (i < toggle_n) ? ~addr : addr;
      tick();
      if (!last_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    miss_detected = 1'b0;
  endtask

  task automatic test_reset();
    bit to;
    rst = 1'b1; memory_data = 16'h5A5A; memory_data_valid = 1'b1;
    #2;
    n_checks++; if (fsm_busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", fsm_busy); end
    n_checks++; if (memory_read !== 1'b0) begin n_errors++; $display("FAIL rst_read: got %b want 0", memory_read); end
    n_checks++; if (memory_address !== 16'h0000) begin n_errors++; $display("FAIL rst_addr: got %h want 0000", memory_address); end
    n_checks++; if (write_data_array !== 1'b0) begin n_errors++; $display("FAIL rst_wr: got %b want 0", write_data_array); end
    n_checks++; if (word_enable !== 8'h00) begin n_errors++; $display("FAIL rst_we: got %h want 00", word_enable); end
    n_checks++; if (write_tag_array !== 1'b0) begin n_errors++; $display("FAIL rst_tag: got %b want 0", write_tag_array); end
    n_checks++; if (fill_data !== 16'h5A5A) begin n_errors++; $display("FAIL rst_fill_data: got %h want 5a5a", fill_data); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; memory_data_valid = 1'b0; memory_data = 16'h0000;

    // Reset in the middle of a fill, while word 3 is on the return bus.
    clear_log(); mem_lat = 2; mem_gap = 0;
    miss_address = 16'h2220; miss_detected = 1'b1;
    tick();
    miss_detected = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (wr_cnt == 3) begin to = 1'b0; break; end
    end
    n_checks++; if (to) begin n_errors++; $display("FAIL rst_mid_wait: got timeout want 3 writes"); end
    #2; rst = 1'b1; #1;
    n_checks++; if (fsm_busy !== 1'b0) begin n_errors++; $display("FAIL mid_rst_busy: got %b want 0", fsm_busy); end
    n_checks++; if (memory_read !== 1'b0) begin n_errors++; $display("FAIL mid_rst_read: got %b want 0", memory_read); end
    n_checks++; if (memory_address !== 16'h0000) begin n_errors++; $display("FAIL mid_rst_addr: got %h want 0000", memory_address); end
    n_checks++; if (write_data_array !== 1'b0) begin n_errors++; $display("FAIL mid_rst_wr: got %b want 0", write_data_array); end
    n_checks++; if (word_enable !== 8'h00) begin n_errors++; $display("FAIL mid_rst_we: got %h want 00", word_enable); end
    n_checks++; if (write_tag_array !== 1'b0) begin n_errors++; $display("FAIL mid_rst_tag: got %b want 0", write_tag_array); end
    tick();
    rst = 1'b0;
    repeat (8) tick();
    n_checks++; if (wr_cnt !== 3) begin n_errors++; $display("FAIL mid_rst_writes: got %0d want 3", wr_cnt); end
    n_checks++; if (req_cnt !== 5) begin n_errors++; $display("FAIL mid_rst_reqs: got %0d want 5", req_cnt); end
    n_checks++; if (tag_cnt !== 0) begin n_errors++; $display("FAIL mid_rst_tagcnt: got %0d want 0", tag_cnt); end
    n_checks++; if (last_busy !== 1'b0) begin n_errors++; $display("FAIL mid_rst_idle: got busy %b want 0", last_busy); end
    n_checks++; if (stray_en !== 0) begin n_errors++; $display("FAIL mid_rst_stray_we: got %0d want 0", stray_en); end
    clear_log();
  endtask

  task automatic test_basic();
    bit to;
    clear_log(); mem_lat = 4; mem_gap = 0;
    run_fill(16'h1236, 0, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL basic_done: got timeout want fill end"); end
    n_checks++; if (req_cnt !== 8) begin n_errors++; $display("FAIL basic_reqs: got %0d want 8", req_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (req_addr[i] !== exp_addr(12'h123, i, 3'd3)) begin
        n_errors++; $display("FAIL basic_addr[%0d]: got %h want %h", i, req_addr[i], exp_addr(12'h123, i, 3'd3));
      end
      n_checks++;
      if (wr_en[i] !== (8'b1 << tb_off(i, 3'd3))) begin
        n_errors++; $display("FAIL basic_we[%0d]: got %h want %h", i, wr_en[i], 8'b1 << tb_off(i, 3'd3));
      end
      n_checks++;
      if (wr_dat[i] !== data_of(exp_addr(12'h123, i, 3'd3))) begin
        n_errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, wr_dat[i], data_of(exp_addr(12'h123, i, 3'd3)));
      end
    end
    n_checks++; if (wr_cnt !== 8) begin n_errors++; $display("FAIL basic_writes: got %0d want 8", wr_cnt); end
    n_checks++; if (tag_cnt !== 1 || tag_wr !== 8) begin n_errors++; $display("FAIL basic_tag: got cnt %0d at write %0d want 1 at 8", tag_cnt, tag_wr); end
    n_checks++; if (tag_en !== (8'b1 << tb_off(7, 3'd3))) begin n_errors++; $display("FAIL basic_tag_we: got %h want %h", tag_en, 8'b1 << tb_off(7, 3'd3)); end
    n_checks++; if (req_cyc[7] - req_cyc[0] !== 7) begin n_errors++; $display("FAIL basic_req_span: got %0d want 7", req_cyc[7] - req_cyc[0]); end
    n_checks++; if (tag_cyc - req_cyc[0] !== 11) begin n_errors++; $display("FAIL basic_tag_time: got %0d want 11", tag_cyc - req_cyc[0]); end
    n_checks++; if (busy_cnt !== 12) begin n_errors++; $display("FAIL basic_busy: got %0d want 12", busy_cnt); end
    n_checks++; if (stray_en !== 0) begin n_errors++; $display("FAIL basic_stray_we: got %0d want 0", stray_en); end
  endtask

  task automatic test_critical_word();
    bit to;
    logic [15:0] ea [8];
    logic [7:0]  ee [8];
    if (CWF) begin
      ea = '{16'h004A, 16'h004C, 16'h004E, 16'h0040, 16'h0042, 16'h0044, 16'h0046, 16'h0048};
      ee = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    end else begin
      ea = '{16'h0040, 16'h0042, 16'h0044, 16'h0046, 16'h0048, 16'h004A, 16'h004C, 16'h004E};
      ee = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    end
    clear_log(); mem_lat = 2; mem_gap = 0;
    run_fill(16'h004A, 0, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL cwf_done: got timeout want fill end"); end
    n_checks++; if (req_cnt !== 8 || wr_cnt !== 8) begin n_errors++; $display("FAIL cwf_counts: got req %0d wr %0d want 8 8", req_cnt, wr_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (req_addr[i] !== ea[i]) begin n_errors++; $display("FAIL cwf_addr[%0d]: got %h want %h", i, req_addr[i], ea[i]); end
      n_checks++;
      if (wr_en[i] !== ee[i]) begin n_errors++; $display("FAIL cwf_we[%0d]: got %h want %h", i, wr_en[i], ee[i]); end
    end
    n_checks++; if (tag_cnt !== 1 || tag_en !== ee[7]) begin n_errors++; $display("FAIL cwf_tag: got cnt %0d we %h want 1 %h", tag_cnt, tag_en, ee[7]); end
  endtask

  task automatic test_bursty();
    bit to;
    clear_log(); mem_lat = 3; mem_gap = 2;
    run_fill(16'hBEE0, 0, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL burst_done: got timeout want fill end"); end
    n_checks++; if (req_cnt !== 8) begin n_errors++; $display("FAIL burst_reqs: got %0d want 8", req_cnt); end
    n_checks++; if (wr_cnt !== 8) begin n_errors++; $display("FAIL burst_writes: got %0d want 8", wr_cnt); end
    n_checks++; if (tag_cnt !== 1 || tag_wr !== 8) begin n_errors++; $display("FAIL burst_tag: got cnt %0d at write %0d want 1 at 8", tag_cnt, tag_wr); end
    n_checks++; if (req_cyc[7] - req_cyc[0] !== 7) begin n_errors++; $display("FAIL burst_req_span: got %0d want 7", req_cyc[7] - req_cyc[0]); end
    n_checks++; if (busy_cnt !== 25) begin n_errors++; $display("FAIL burst_busy: got %0d want 25", busy_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (wr_dat[i] !== data_of(exp_addr(12'hBEE, i, 3'd0))) begin
        n_errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, wr_dat[i], data_of(exp_addr(12'hBEE, i, 3'd0)));
      end
    end
    mem_gap = 0;
  endtask

  task automatic test_stray();
    bit to;
    clear_log(); mem_lat = 4;
    inj_valid = 1'b1;
    repeat (4) tick();
    inj_valid = 1'b0;
    tick();
    n_checks++; if (wr_cnt !== 0 || tag_cnt !== 0) begin n_errors++; $display("FAIL stray_idle_writes: got wr %0d tag %0d want 0 0", wr_cnt, tag_cnt); end
    n_checks++; if (req_cnt !== 0 || busy_cnt !== 0) begin n_errors++; $display("FAIL stray_idle_start: got req %0d busy %0d want 0 0", req_cnt, busy_cnt); end
    n_checks++; if (stray_en !== 0) begin n_errors++; $display("FAIL stray_idle_we: got %0d want 0", stray_en); end
    clear_log();
    run_fill(16'h7772, 6, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL stray_fill_done: got timeout want fill end"); end
    n_checks++; if (req_cnt !== 8) begin n_errors++; $display("FAIL stray_fill_reqs: got %0d want 8", req_cnt); end
    n_checks++; if (wr_cnt !== 8 || tag_cnt !== 1) begin n_errors++; $display("FAIL stray_fill_writes: got wr %0d tag %0d want 8 1", wr_cnt, tag_cnt); end
    n_checks++; if (busy_cnt !== 12) begin n_errors++; $display("FAIL stray_fill_busy: got %0d want 12", busy_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (req_addr[i] !== exp_addr(12'h777, i, 3'd1)) begin
        n_errors++; $display("FAIL stray_fill_addr[%0d]: got %h want %h", i, req_addr[i], exp_addr(12'h777, i, 3'd1));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int busy_first, tag_first;
    clear_log(); mem_lat = 3;
    miss_address = 16'h0F08; miss_detected = 1'b1;
    tick();
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!last_busy) begin to = 1'b0; break; end
    end
    busy_first = busy_cnt; tag_first = tag_cyc;
    miss_detected = 1'b0;
    n_checks++; if (to) begin n_errors++; $display("FAIL b2b_first_done: got timeout want fill end"); end
    n_checks++; if (busy_first !== 11) begin n_errors++; $display("FAIL b2b_first_busy: got %0d want 11", busy_first); end
    tick();
    n_checks++; if (last_busy !== 1'b1) begin n_errors++; $display("FAIL b2b_restart: got busy %b want 1", last_busy); end
    n_checks++; if (req_cnt !== 9) begin n_errors++; $display("FAIL b2b_restart_req: got %0d want 9", req_cnt); end
    n_checks++; if (req_addr[8] !== exp_addr(12'h0F0, 0, 3'd4)) begin n_errors++; $display("FAIL b2b_first_addr: got %h want %h", req_addr[8], exp_addr(12'h0F0, 0, 3'd4)); end
    n_checks++; if (req_cyc[8] - tag_first !== 2) begin n_errors++; $display("FAIL b2b_gap: got %0d want 2", req_cyc[8] - tag_first); end
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!last_busy) begin to = 1'b0; break; end
    end
    n_checks++; if (to) begin n_errors++; $display("FAIL b2b_second_done: got timeout want fill end"); end
    n_checks++; if (req_cnt !== 16 || wr_cnt !== 16) begin n_errors++; $display("FAIL b2b_counts: got req %0d wr %0d want 16 16", req_cnt, wr_cnt); end
    n_checks++; if (tag_cnt !== 2 || tag_wr !== 16) begin n_errors++; $display("FAIL b2b_tag: got cnt %0d at write %0d want 2 at 16", tag_cnt, tag_wr); end
    n_checks++; if (wr_en[8] !== (8'b1 << tb_off(0, 3'd4))) begin n_errors++; $display("FAIL b2b_first_we: got %h want %h", wr_en[8], 8'b1 << tb_off(0, 3'd4)); end
    n_checks++; if (busy_cnt !== 22) begin n_errors++; $display("FAIL b2b_busy: got %0d want 22", busy_cnt); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    mem_lat = 4; mem_gap = 0; inj_valid = 1'b0;
    miss_detected = 1'b0; miss_address = 16'h0000;
    memory_data = 16'h0000; memory_data_valid = 1'b0;
    clear_log();
    test_reset();
    test_basic();
    test_critical_word();
    test_bursty();
    test_stray();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion within 200000 time units");
    $fatal(1);
  end

endmodule
